// File: rtl/light_pkg.sv
// Shared light-code definitions, direction indices and helpers for the light phase sequencer.
package light_pkg;

    typedef logic [2:0] light_code;

    localparam light_code Stop         = 3'b000;
    localparam light_code Forward_only = 3'b001;
    localparam light_code Left_only    = 3'b010;
    localparam light_code Right_only   = 3'b011;
    localparam light_code Go           = 3'b100;

    localparam int N = 0;
    localparam int S = 1;
    localparam int E = 2;
    localparam int W = 3;

    // Undefined encodings collapse to Stop so they can never open a direction.
    function automatic light_code sanitise(input light_code c);
        if (c == Forward_only || c == Left_only || c == Right_only || c == Go)
            return c;
        return Stop;
    endfunction

    function automatic int cntWidth(input int maxVal);
        if (maxVal < 1)
            return 1;
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/light_sat_counter.sv
// Up-counter that saturates at MAX_VAL, with synchronous reset, synchronous clear and enable.
module light_sat_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && count < MAX_VAL)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/light_phase_sequencer.sv
// Registered safety stage between the stop-light controller and the intersection: minimum hold,
// all-Stop clearance gated by center_busy. Optional clearance watchdog: LIGHT_PHASE_WATCHDOG_EN.
//
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_CLEAR | all directions Stop; wait CLEAR_CYCLES and an empty centre
//   ST_HOLD  | latched pattern shown; only Stop-only changes before MIN_HOLD
module light_phase_sequencer
    import light_pkg::*;
#(
    parameter int MIN_HOLD     = 8,
    parameter int CLEAR_CYCLES = 4,
    parameter int WDOG_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] reqN,
    input  logic [2:0] reqS,
    input  logic [2:0] reqE,
    input  logic [2:0] reqW,
    input  logic       center_busy,
    output logic [2:0] outN,
    output logic [2:0] outS,
    output logic [2:0] outE,
    output logic [2:0] outW,
    output logic       fault
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int HOLD_W = cntWidth(MIN_HOLD - 1);
    localparam int CLR_W  = cntWidth(CLEAR_CYCLES - 1);

    if (MIN_HOLD < 1 || CLEAR_CYCLES < 1 || WDOG_CYCLES < 1) begin : gBadParams
        $error("light_phase_sequencer: MIN_HOLD, CLEAR_CYCLES and WDOG_CYCLES must be >= 1");
    end

    logic [0:0]        state;
    light_code         req  [4];
    light_code         disp [4];
    logic [HOLD_W-1:0] holdCnt;
    logic [CLR_W-1:0]  clrCnt;
    logic              anyDiff;
    logic              stopOnly;
    logic              holdDone;
    logic              clrDone;

    assign req[N] = sanitise(reqN);
    assign req[S] = sanitise(reqS);
    assign req[E] = sanitise(reqE);
    assign req[W] = sanitise(reqW);

    assign outN = disp[N];
    assign outS = disp[S];
    assign outE = disp[E];
    assign outW = disp[W];

    light_sat_counter #(
        .WIDTH   (HOLD_W),
        .MAX_VAL (HOLD_W'(MIN_HOLD - 1))
    ) uHoldCnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != ST_HOLD),
        .en    (state == ST_HOLD),
        .count (holdCnt)
    );

    light_sat_counter #(
        .WIDTH   (CLR_W),
        .MAX_VAL (CLR_W'(CLEAR_CYCLES - 1))
    ) uClrCnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != ST_CLEAR),
        .en    (state == ST_CLEAR),
        .count (clrCnt)
    );

    assign holdDone = (holdCnt >= HOLD_W'(MIN_HOLD - 1));
    assign clrDone  = (clrCnt >= CLR_W'(CLEAR_CYCLES - 1));

    // A change is Stop-only when every differing direction is now requesting Stop.
    always_comb begin
        anyDiff  = 1'b0;
        stopOnly = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (req[d] != disp[d]) begin
                anyDiff = 1'b1;
                if (req[d] != Stop)
                    stopOnly = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            for (int d = 0; d < 4; d++)
                disp[d] <= Stop;
        end else begin
            case (state)
                ST_CLEAR: begin
                    for (int d = 0; d < 4; d++)
                        disp[d] <= Stop;
                    if (clrDone && !center_busy) begin
                        state <= ST_HOLD;
                        for (int d = 0; d < 4; d++)
                            disp[d] <= req[d];
                    end
                end
                ST_HOLD: begin
                    if (anyDiff) begin
                        if (stopOnly) begin
                            for (int d = 0; d < 4; d++)
                                disp[d] <= req[d];
                        end else if (holdDone) begin
                            state <= ST_CLEAR;
                            for (int d = 0; d < 4; d++)
                                disp[d] <= Stop;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

`ifdef LIGHT_PHASE_WATCHDOG_EN
    localparam int WD_W = cntWidth(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wdogCnt;

    light_sat_counter #(
        .WIDTH   (WD_W),
        .MAX_VAL (WD_W'(WDOG_CYCLES - 1))
    ) uWdogCnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != ST_CLEAR),
        .en    (state == ST_CLEAR),
        .count (wdogCnt)
    );

    // Trips at the end of the WDOG_CYCLES-th consecutive CLEAR cycle; only rst releases it.
    always_ff @(posedge clk) begin
        if (rst)
            fault <= 1'b0;
        else if (state == ST_CLEAR && wdogCnt == WD_W'(WDOG_CYCLES - 1))
            fault <= 1'b1;
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Scoreboard bench for light_phase_sequencer with MIN_HOLD=4, CLEAR_CYCLES=2, WDOG_CYCLES=16.
module tb_light_phase_sequencer;

    localparam logic [2:0] cStop = 3'b000;
    localparam logic [2:0] cLeft = 3'b010;
    localparam logic [2:0] cGo   = 3'b100;
    localparam logic [2:0] cBad  = 3'b110;

`ifdef LIGHT_PHASE_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [11:0] outs;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] reqN = cStop, reqS = cStop, reqE = cStop, reqW = cStop;
    logic       center_busy = 1'b0;
    logic [2:0] outN, outS, outE, outW;
    logic       fault;

    exp_t sb[$];
    int   cycleIdx = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    light_phase_sequencer #(
        .MIN_HOLD     (4),
        .CLEAR_CYCLES (2),
        .WDOG_CYCLES  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reqN        (reqN),
        .reqS        (reqS),
        .reqE        (reqE),
        .reqW        (reqW),
        .center_busy (center_busy),
        .outN        (outN),
        .outS        (outS),
        .outE        (outE),
        .outW        (outW),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // One cycle: expected outputs are those visible in this cycle; inputs are sampled at its end.
    task automatic cyc(input logic r, input logic [2:0] n, s, e, w, input logic b,
                       input logic [2:0] xn, xs, xe, xw, input logic xf);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        reqN = n; reqS = s; reqE = e; reqW = w;
        center_busy = b;
        x.idx  = cycleIdx;
        x.outs = {xn, xs, xe, xw};
        x.f    = xf;
        sb.push_back(x);
        cycleIdx++;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            nCompared++;
            if ({outN, outS, outE, outW, fault} !== {x.outs, x.f}) begin
                nMismatched++;
                $display("FAIL cycle%0d outNSEW/fault: got %h %h %h %h / %b, required %h %h %h %h / %b",
                         x.idx, outN, outS, outE, outW, fault,
                         x.outs[11:9], x.outs[8:6], x.outs[5:3], x.outs[2:0], x.f);
            end
        end
    end

    initial begin
        // Power-up: three reset cycles, then two Stop cycles before outN=Go.
        repeat (3) cyc(1, cGo, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);
        repeat (2) cyc(0, cGo, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);
        cyc(0, cGo, cStop, cStop, cStop, 0, cGo, cStop, cStop, cStop, 0);

        // Minimum hold: switch to E at hold_cnt=1, outN=Go stays 4 cycles in total.
        repeat (3) cyc(0, cStop, cStop, cGo, cStop, 0, cGo, cStop, cStop, cStop, 0);
        repeat (2) cyc(0, cStop, cStop, cGo, cStop, 0, cStop, cStop, cStop, cStop, 0);

        // Move to N+S Go through a full hold and clearance.
        repeat (4) cyc(0, cGo, cGo, cStop, cStop, 0, cStop, cStop, cGo, cStop, 0);
        repeat (2) cyc(0, cGo, cGo, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);

        // Stop-only: drop S at hold_cnt=0, applied next cycle without clearance.
        cyc(0, cGo, cStop, cStop, cStop, 0, cGo, cGo, cStop, cStop, 0);
        cyc(0, cGo, cStop, cStop, cStop, 0, cGo, cStop, cStop, cStop, 0);
        cyc(0, cStop, cStop, cStop, cStop, 0, cGo, cStop, cStop, cStop, 0);

        // Sanitise: W=110 is treated as Stop, so HOLD persists and the next Go needs full clearance.
        cyc(0, cStop, cStop, cStop, cBad, 0, cStop, cStop, cStop, cStop, 0);
        cyc(0, cStop, cStop, cStop, cBad, 0, cStop, cStop, cStop, cStop, 0);
        cyc(0, cGo, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);

        // Busy centre for 10 CLEAR cycles with transient requests; only the exit sample is shown.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1)
                cyc(0, cStop, cStop, cGo, cStop, 1, cStop, cStop, cStop, cStop, 0);
            else
                cyc(0, cStop, cStop, cStop, cLeft, 1, cStop, cStop, cStop, cStop, 0);
        end
        cyc(0, cLeft, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);
        repeat (4) cyc(0, cGo, cStop, cStop, cStop, 0, cLeft, cStop, cStop, cStop, 0);

        // Watchdog: busy stuck in CLEAR; fault after 16 CLEAR cycles only when the feature is built.
        for (int i = 0; i < 17; i++)
            cyc(0, cGo, cStop, cStop, cStop, 1, cStop, cStop, cStop, cStop, WD && (i == 16));
        cyc(0, cGo, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, WD);
        cyc(1, cGo, cStop, cStop, cStop, 0, cGo, cStop, cStop, cStop, WD);

        // Reset mid-operation clears outputs and fault at the next edge.
        cyc(0, cStop, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);
        cyc(0, cStop, cStop, cStop, cStop, 0, cStop, cStop, cStop, cStop, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nMismatched++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
